// File: rtl/pipe_addsub.sv
// Pipelined add/subtract unit: the carry chain is cut into STAGES equal slices, one per cycle,
// with carry/overflow/zero flags, a valid tag, and stall/flush hooks for the hazard unit.
module pipe_addsub #(
    parameter int WIDTH  = 32,  // must be a multiple of STAGES
    parameter int STAGES = 2    // 1..8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic [1:0]       op,
    input  logic             cin,
    input  logic [WIDTH-1:0] inp1,
    input  logic [WIDTH-1:0] inp2,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int SW   = WIDTH / STAGES;
    localparam int MSB  = WIDTH - 1;
    localparam int LAST = STAGES - 1;

    // One in-flight slot: A and B' travel whole (upper slices still to be added, MSBs for ovf),
    // sum fills in slice by slice, c is the carry into the next slice.
    typedef struct packed {
        logic             vld;
        logic             c;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sum;
    } stage_t;

    function automatic stage_t add_slice(input stage_t s, input int k);
        stage_t     res;
        logic [SW:0] slice;
        res   = s;
        slice = {1'b0, s.a[k*SW +: SW]} + {1'b0, s.b[k*SW +: SW]} + {{SW{1'b0}}, s.c};
        res.sum[k*SW +: SW] = slice[SW-1:0];
        res.c               = slice[SW];
        return res;
    endfunction

    logic [WIDTH-1:0] w_b0;
    logic             w_c0;
    stage_t           w_st  [STAGES];  // input of stage k
    stage_t           w_res [STAGES];  // output of stage k
    stage_t           w_fin;

    // Subtraction is A + ~B + 1; op 11 lets the caller chain a borrow through cin instead.
    assign w_b0 = op[0] ? ~inp2 : inp2;
    assign w_c0 = (op == 2'b01) ? 1'b1 : (op[1] ? cin : 1'b0);

    assign w_st[0] = '{vld: in_valid, c: w_c0, a: inp1, b: w_b0, sum: '0};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        assign w_res[k] = add_slice(w_st[k], k);

        // The last slice feeds the output registers directly, so only STAGES-1 slot registers exist.
        if (k < LAST) begin : g_pipe
            stage_t r_st;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_st <= '0;
                end else if (flush) begin
                    r_st.vld <= 1'b0;
                end else if (!stall) begin
                    // NOTE: payload is captured only for valid slots; a bubble just clears vld,
                    // so the datapath does not toggle on idle cycles.
                    if (w_res[k].vld) begin
                        r_st <= w_res[k];
                    end else begin
                        r_st.vld <= 1'b0;
                    end
                end
            end

            assign w_st[k+1] = r_st;
        end
    end

    assign w_fin = w_res[LAST];

    // Result registers keep the last completed result across bubbles and flushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (!stall) begin
            out_valid <= w_fin.vld;
            if (w_fin.vld) begin
                out  <= w_fin.sum;
                cout <= w_fin.c;
                ovf  <= (w_fin.a[MSB] == w_fin.b[MSB]) && (w_fin.sum[MSB] != w_fin.a[MSB]);
                zero <= (w_fin.sum == '0);
            end
        end
    end

endmodule
